// File: rtl/back_sprite.sv
// Tiled background strip renderer: maps the current VGA pixel to a sprite ROM address
// and turns the returned RRRGGGBB byte into a colour, zero outside the window or on blank/key.
module back_sprite #(
   parameter int unsigned TILE_W_LOG2 = 5,
   parameter int unsigned TILE_H_LOG2 = 4,
   parameter int unsigned SHEET_W     = 32,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned TRANSP_EN   = 1,
   parameter logic [7:0]  TRANSP_KEY  = 8'hE3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       x0,
   input  logic [10:0]       y0,
   input  logic [10:0]       x1,
   input  logic [10:0]       y1,
   input  logic [10:0]       hc,
   input  logic [10:0]       vc,
   input  logic              blank,
   input  logic [9:0]        sprite_num,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        mem_value,
   output logic [2:0]        R,
   output logic [2:0]        G,
   output logic [1:0]        B
);

   logic                   in_win;
   logic                   vis_d;
   logic                   key_hit;
   logic [TILE_W_LOG2-1:0] col;
   logic [TILE_H_LOG2-1:0] row;

   // Window test and tile-wrapped ROM address for the current pixel
   always_comb begin
      in_win   = (hc >= x0) && (hc < x1) && (vc >= y0) && (vc < y1);
      col      = TILE_W_LOG2'(hc - x0);
      row      = TILE_H_LOG2'(vc - y0);
      rom_addr = '0;
      if (in_win) begin
         rom_addr = ADDR_W'(32'(row) * 32'(SHEET_W) + 32'(sprite_num) + 32'(col));
      end
   end

   // Visibility delayed one clock to line up with the ROM read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vis_d <= 1'b0;
      end else begin
         vis_d <= in_win & ~blank;
      end
   end

   always_comb begin
      key_hit   = (TRANSP_EN != 0) && (mem_value == TRANSP_KEY);
      {R, G, B} = (vis_d && !key_hit) ? mem_value : 8'h00;
   end

endmodule

// File: tb/tb_back_sprite.sv
// Self-checking bench for back_sprite: directed cases plus randomized windows/pixels
// checked against an arithmetic reference model and a behavioural ROM.
module tb_back_sprite;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] x0, y0, x1, y1, hc, vc;
   logic        blank;
   logic [9:0]  sprite_num;
   logic [15:0] rom_addr, rom_addr_nt;
   logic [7:0]  mem_value;
   logic [2:0]  r, g, r_nt, g_nt;
   logic [1:0]  b, b_nt;

   logic [7:0]  rom [0:65535];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Synchronous ROM: data valid one clock after the address
   always @(posedge clk) mem_value <= rom[rom_addr];

   back_sprite u_dut (
      .clk(clk), .rst(rst), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .hc(hc), .vc(vc), .blank(blank), .sprite_num(sprite_num),
      .rom_addr(rom_addr), .mem_value(mem_value), .R(r), .G(g), .B(b)
   );

   back_sprite #(.TRANSP_EN(0)) u_dut_nt (
      .clk(clk), .rst(rst), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .hc(hc), .vc(vc), .blank(blank), .sprite_num(sprite_num),
      .rom_addr(rom_addr_nt), .mem_value(mem_value), .R(r_nt), .G(g_nt), .B(b_nt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_in_win(input int h, input int v);
      return h >= int'(x0) && h < int'(x1) && v >= int'(y0) && v < int'(y1);
   endfunction

   function automatic int model_addr(input int h, input int v);
      if (!model_in_win(h, v)) return 0;
      return (((v - int'(y0)) % 16) * 32 + int'(sprite_num) + (h - int'(x0)) % 32) % 65536;
   endfunction

   function automatic int model_rgb(input int addr, input bit vis, input bit transp);
      int val;
      val = int'(rom[addr]);
      if (!vis) return 0;
      if (transp && val == 'hE3) return 0;
      return val;
   endfunction

   // One pixel: drive at negedge, check address, then check colour after the next posedge
   task automatic pix(input int h, input int v, input bit bl, input string tag);
      int ea;
      bit vis;
      @(negedge clk);
      hc    = 11'(h);
      vc    = 11'(v);
      blank = bl;
      #1;
      ea  = model_addr(h, v);
      vis = model_in_win(h, v) && !bl;
      chk({tag, "_addr"}, 32'(rom_addr), 32'(ea));
      chk({tag, "_addr_nt"}, 32'(rom_addr_nt), 32'(ea));
      @(posedge clk);
      #1;
      chk({tag, "_rgb"}, 32'({r, g, b}), 32'(model_rgb(ea, vis, 1'b1)));
      chk({tag, "_rgb_nt"}, 32'({r_nt, g_nt, b_nt}), 32'(model_rgb(ea, vis, 1'b0)));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
      rst = 1'b0;
      x0 = 11'd0; y0 = 11'd470; x1 = 11'd640; y1 = 11'd480;
      hc = 11'd37; vc = 11'd472; blank = 1'b0; sprite_num = 10'd0;
      #12;
      chk("reset_rgb", 32'({r, g, b}), 32'd0);
      chk("reset_addr_comb", 32'(rom_addr), 32'd69);
      @(negedge clk);
      rst = 1'b1;

      // Basic pixel and spec constants
      rom[69] = 8'b101_010_01;
      pix(37, 472, 1'b0, "t1");
      chk("t1_const", 32'({r, g, b}), 32'h0A9);
      rom[0] = 8'hFF;
      pix(37, 469, 1'b0, "t2_outside");
      chk("t2_const", 32'({r, g, b}), 32'd0);
      rom[69] = 8'hFF;
      pix(37, 472, 1'b1, "t3_blank");
      rom[69] = 8'hE3;
      pix(37, 472, 1'b0, "t3_key");
      chk("t3_key_nt_const", 32'({r_nt, g_nt, b_nt}), 32'hE3);

      // Window edges and sprite offset
      pix(639, 472, 1'b0, "t4_right");
      chk("t4_col31", 32'(rom_addr), 32'd95);
      pix(640, 472, 1'b0, "t4_past_right");
      pix(0, 480, 1'b0, "t4_past_bottom");
      pix(0, 470, 1'b0, "t4_corner");
      sprite_num = 10'd32;
      pix(0, 470, 1'b0, "t4_sprite");
      chk("t4_sprite_const", 32'(rom_addr), 32'd32);
      sprite_num = 10'd0;

      // Full line stream: colour trails the address by one clock
      for (int h = 0; h < 640; h++) pix(h, 475, 1'b0, "t5_stream");

      // Asynchronous reset while showing a colour
      rom[69] = 8'hA9;
      pix(37, 472, 1'b0, "t6_pre");
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("t6_async_clear", 32'({r, g, b}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("t6_resume", 32'({r, g, b}), 32'hA9);

      // Randomized windows, pixels and sprite offsets
      for (int i = 0; i < 600; i++) begin
         if (i % 20 == 0) begin
            x0 = 11'($urandom_range(0, 600));
            x1 = 11'($urandom_range(0, 800));
            y0 = 11'($urandom_range(0, 400));
            y1 = 11'($urandom_range(0, 500));
            sprite_num = 10'($urandom_range(0, 1023));
         end
         if (i % 7 == 0) rom[$urandom_range(0, 2047)] = 8'hE3;
         pix($urandom_range(0, 800), $urandom_range(0, 500), 1'($urandom_range(0, 4) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
